spi_master_cmd_ctrl: RTL and testbench

Host-side SPI mode-3 master that turns single-word command requests into framed command transactions for the remote pulse-generator slave. It covers machine start/stop, Ton/Toff/Ip/waveform writes and 32-bit feedback reads. It sits between the host control logic and the board-to-board SPI pins, and returns captured feedback words on a valid strobe.

---
 rtl/spi_cmd_pkg.sv | 63 ++++++
 rtl/spi_master_cmd_ctrl_if.sv | 22 ++
 rtl/spi_cmd_fifo.sv | 48 ++++
 rtl/spi_master_cmd_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_spi_master_cmd_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared constants, types and frame helpers for the SPI command master.
package spi_cmd_pkg;

    localparam logic [2:0] OP_START = 3'd0;
    localparam logic [2:0] OP_STOP  = 3'd1;
    localparam logic [2:0] OP_TON   = 3'd2;
    localparam logic [2:0] OP_TOFF  = 3'd3;
    localparam logic [2:0] OP_IP    = 3'd4;
    localparam logic [2:0] OP_WAVE  = 3'd5;
    localparam logic [2:0] OP_FB    = 3'd6;
    localparam logic [2:0] OP_INV   = 3'd7;

    localparam logic [7:0] OPC_START = 8'h06;
    localparam logic [7:0] OPC_STOP  = 8'h04;
    localparam logic [7:0] OPC_TON   = 8'h91;
    localparam logic [7:0] OPC_TOFF  = 8'h9E;
    localparam logic [7:0] OPC_IP    = 8'h93;
    localparam logic [7:0] OPC_WAVE  = 8'h9C;
    localparam logic [7:0] OPC_FB    = 8'hAB;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_GAP   = 3'd3;
    localparam state_t ST_HOLD  = 3'd4;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] data;
    } cmd_t;

    function automatic logic [2:0] frame_bytes(input logic [2:0] op);
        case (op)
            OP_START, OP_STOP:               return 3'd1;
            OP_TON, OP_TOFF, OP_IP, OP_WAVE: return 3'd3;
            OP_FB:                           return 3'd5;
            default:                         return 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] opcode_byte(input logic [2:0] op);
        case (op)
            OP_START: return OPC_START;
            OP_STOP:  return OPC_STOP;
            OP_TON:   return OPC_TON;
            OP_TOFF:  return OPC_TOFF;
            OP_IP:    return OPC_IP;
            OP_WAVE:  return OPC_WAVE;
            OP_FB:    return OPC_FB;
            default:  return 8'hFF;
        endcase
    endfunction

    // Byte idx of the frame: opcode, then payload little-endian or 0xFF dummies.
    function automatic logic [7:0] frame_byte(input logic [2:0] op, input logic [15:0] data,
                                              input logic [2:0] idx);
        if (idx == 3'd0) return opcode_byte(op);
        if (op == OP_FB) return 8'hFF;
        return (idx == 3'd1) ? data[7:0] : data[15:8];
    endfunction

endpackage

// File: rtl/spi_master_cmd_ctrl_if.sv
// Host-side command/status bundle of the SPI command master.
interface spi_master_cmd_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        busy;
    logic        done;
    logic        cmd_err;
    logic [31:0] fb_data;
    logic        fb_valid;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, busy, done, cmd_err, fb_data, fb_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, busy, done, cmd_err, fb_data, fb_valid
    );
endinterface

// File: rtl/spi_cmd_fifo.sv
// Small show-ahead command FIFO placed in front of the SPI frame FSM.
module spi_cmd_fifo
    import spi_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/spi_master_cmd_ctrl.sv
// SPI mode-3 command master for the pulse-generator slave.
// Define SPI_MASTER_CMD_QUEUE_EN to put a 4-entry command FIFO in front of the FSM.
module spi_master_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 4,
    parameter int BYTE_GAP = 16,
    parameter int CS_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_master_cmd_ctrl_if.slave cmd,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 mosi,
    input  logic                 miso
);
    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_M1 = 16'(CS_SETUP - 1);
    localparam logic [15:0] GAP_M1   = 16'(BYTE_GAP - 1);
    localparam logic [15:0] HOLD_M1  = 16'(CS_HOLD - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx, byte_idx;
    logic        hold_hi;
    logic [2:0]  cur_op;
    logic [15:0] cur_data;
    logic [7:0]  rx_sh;
    logic [31:0] fb_sh;
    logic        done_q, err_q, fbv_q;
    logic [31:0] fb_q;

    logic        launch;
    cmd_t        launch_cmd;
    logic [7:0]  launch_opc;
    logic [7:0]  cur_byte;
    logic [2:0]  nbytes;
    logic        last_byte;
    logic        cnt_end;

    assign launch_opc = opcode_byte(launch_cmd.op);
    assign cur_byte   = frame_byte(cur_op, cur_data, byte_idx);
    assign nbytes     = frame_bytes(cur_op);
    assign last_byte  = (byte_idx == nbytes - 3'd1);

    always_comb begin
        cnt_end = 1'b0;
        case (state)
            ST_SETUP: cnt_end = (cnt == SETUP_M1);
            ST_SHIFT: cnt_end = (cnt == DIV_M1);
            ST_GAP:   cnt_end = (cnt == GAP_M1);
            ST_HOLD:  cnt_end = (cnt == HOLD_M1);
            default:  cnt_end = 1'b0;
        endcase
    end

`ifdef SPI_MASTER_CMD_QUEUE_EN
    cmd_t push_cmd, fifo_dout;
    logic fifo_full, fifo_empty, hold_end;

    assign push_cmd = {cmd.cmd_op, cmd.cmd_data};
    // Popping straight out of the cs_n-high hold keeps queued frames CS_HOLD apart.
    assign hold_end   = (state == ST_HOLD) && hold_hi && cnt_end;
    assign launch     = !fifo_empty && ((state == ST_IDLE) || hold_end);
    assign launch_cmd = fifo_dout;

    assign cmd.cmd_ready = !fifo_full;
    assign cmd.busy      = (state != ST_IDLE) || !fifo_empty;

    spi_cmd_fifo #(.DEPTH(4)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd.cmd_valid),
        .din   (push_cmd),
        .pop   (launch),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
`else
    assign launch_cmd    = {cmd.cmd_op, cmd.cmd_data};
    assign launch        = (state == ST_IDLE) && !err_q && cmd.cmd_valid;
    assign cmd.cmd_ready = (state == ST_IDLE) && !err_q;
    assign cmd.busy      = (state != ST_IDLE);
`endif

    assign cmd.done     = done_q;
    assign cmd.cmd_err  = err_q;
    assign cmd.fb_valid = fbv_q;
    assign cmd.fb_data  = fb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= 3'd7;
            byte_idx <= '0;
            hold_hi  <= 1'b0;
            cur_op   <= OP_START;
            cur_data <= '0;
            rx_sh    <= '0;
            fb_sh    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fbv_q    <= 1'b0;
            fb_q     <= '0;
            sclk     <= 1'b1;
            cs_n     <= 1'b1;
            mosi     <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            fbv_q  <= 1'b0;

            case (state)
                ST_SETUP: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        sclk  <= 1'b0;
                        state <= ST_SHIFT;
                    end else cnt <= cnt + 16'd1;
                end
                ST_SHIFT: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        if (!sclk) begin
                            sclk  <= 1'b1;
                            rx_sh <= {rx_sh[6:0], miso};
                        end else if (bit_idx != 3'd0) begin
                            sclk    <= 1'b0;
                            bit_idx <= bit_idx - 3'd1;
                            mosi    <= cur_byte[bit_idx - 3'd1];
                        end else begin
                            // Dummy bytes land LSB-byte first; the opcode-time byte is dropped.
                            if (byte_idx != 3'd0) fb_sh <= {rx_sh, fb_sh[31:8]};
                            if (last_byte) state <= ST_HOLD;
                            else begin
                                state    <= ST_GAP;
                                byte_idx <= byte_idx + 3'd1;
                            end
                        end
                    end else cnt <= cnt + 16'd1;
                end
                ST_GAP: begin
                    if (cnt_end) begin
                        cnt     <= '0;
                        sclk    <= 1'b0;
                        mosi    <= cur_byte[7];
                        bit_idx <= 3'd7;
                        state   <= ST_SHIFT;
                    end else cnt <= cnt + 16'd1;
                end
                ST_HOLD: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        if (!hold_hi) begin
                            cs_n    <= 1'b1;
                            mosi    <= 1'b1;
                            done_q  <= 1'b1;
                            hold_hi <= 1'b1;
                            if (cur_op == OP_FB) begin
                                fbv_q <= 1'b1;
                                fb_q  <= fb_sh;
                            end
                        end else state <= ST_IDLE;
                    end else cnt <= cnt + 16'd1;
                end
                default: state <= ST_IDLE;
            endcase

            // Placed after the case so a pop at the end of the hold overrides the return to IDLE.
            if (launch) begin
                cnt <= '0;
                if (launch_cmd.op == OP_INV) begin
                    err_q <= 1'b1;
                    state <= ST_IDLE;
                end else begin
                    cur_op   <= launch_cmd.op;
                    cur_data <= launch_cmd.data;
                    cs_n     <= 1'b0;
                    mosi     <= launch_opc[7];
                    bit_idx  <= 3'd7;
                    byte_idx <= '0;
                    hold_hi  <= 1'b0;
                    state    <= ST_SETUP;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_master_cmd_ctrl.sv
// Randomised self-checking bench: SPI slave model plus frame-level reference model.
module tb_spi_master_cmd_ctrl;
    localparam int CLK_DIV  = 8;
    localparam int CS_SETUP = 4;
    localparam int BYTE_GAP = 16;
    localparam int CS_HOLD  = 8;

    typedef struct {
        int          start_cyc;
        int          first_fall;
        int          end_cyc;
        int          low;
        int          rises;
        int          gap;
        logic [39:0] bits;
        logic        done_at_end;
        logic        fbv;
        logic [31:0] fbd;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sclk, cs_n, mosi, miso;

    spi_master_cmd_ctrl_if cmd_if ();

    spi_master_cmd_ctrl #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .BYTE_GAP(BYTE_GAP),
        .CS_HOLD (CS_HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cmd  (cmd_if),
        .sclk (sclk),
        .cs_n (cs_n),
        .mosi (mosi),
        .miso (miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int done_cnt = 0, fbv_cnt = 0, err_cnt = 0, stray = 0, cs_fall_cnt = 0;
    int exp_done = 0, exp_fbv = 0, exp_err = 0;
    logic [31:0] exp_fb = '0;
    logic [7:0]  resp [5];
    frame_t      frames [$];
    frame_t      fr;
    logic        in_frame = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b1;
    logic [31:0] prev_fbd = '0;
    int          last_end = 0, last_low = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: bytes of a frame as seen on MOSI, right-aligned, first byte most significant.
    function automatic int exp_nbytes(input logic [2:0] op);
        if (op <= 3'd1) return 1;
        if (op <= 3'd5) return 3;
        if (op == 3'd6) return 5;
        return 0;
    endfunction

    function automatic logic [39:0] exp_bits(input logic [2:0] op, input logic [15:0] data);
        logic [7:0]  b [5];
        logic [39:0] r;
        case (op)
            3'd0: b[0] = 8'h06;
            3'd1: b[0] = 8'h04;
            3'd2: b[0] = 8'h91;
            3'd3: b[0] = 8'h9E;
            3'd4: b[0] = 8'h93;
            3'd5: b[0] = 8'h9C;
            default: b[0] = 8'hAB;
        endcase
        b[1] = (op == 3'd6) ? 8'hFF : data[7:0];
        b[2] = (op == 3'd6) ? 8'hFF : data[15:8];
        b[3] = 8'hFF;
        b[4] = 8'hFF;
        r = '0;
        for (int i = 0; i < exp_nbytes(op); i++) r = {r[31:0], b[i]};
        return r;
    endfunction

    // Bus monitor and mode-3 slave: drives miso on SCLK fall, captures mosi on SCLK rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 1'b0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b1;
            miso      = 1'b1;
        end else begin
            if (cmd_if.done)     done_cnt++;
            if (cmd_if.fb_valid) fbv_cnt++;
            if (cmd_if.cmd_err)  err_cnt++;
            if (cmd_if.fb_valid && !cmd_if.done) stray++;
            if (!cmd_if.fb_valid && cmd_if.fb_data !== prev_fbd) stray++;
            if (cs_n && !sclk) stray++;
            if (prev_cs && !cs_n) begin
                in_frame      = 1'b1;
                cs_fall_cnt++;
                fr.start_cyc  = cyc;
                fr.first_fall = -1;
                fr.low        = 0;
                fr.rises      = 0;
                fr.bits       = '0;
                fr.gap        = cyc - last_end;
            end
            if (!cs_n) begin
                fr.low++;
                if (prev_sclk && !sclk) begin
                    if (fr.first_fall < 0) fr.first_fall = cyc;
                    if (fr.rises < 40) miso = resp[fr.rises / 8][7 - fr.rises % 8];
                end
                if (!prev_sclk && sclk) begin
                    fr.bits = {fr.bits[38:0], mosi};
                    fr.rises++;
                end
            end
            if (!prev_cs && cs_n && in_frame) begin
                fr.end_cyc     = cyc;
                fr.done_at_end = cmd_if.done;
                fr.fbv         = cmd_if.fb_valid;
                fr.fbd         = cmd_if.fb_data;
                frames.push_back(fr);
                last_end = cyc;
                in_frame = 1'b0;
                miso     = 1'b1;
            end
            prev_cs   = cs_n;
            prev_sclk = sclk;
        end
        prev_fbd = cmd_if.fb_data;
    end

    task automatic rand_resp();
        for (int i = 0; i < 5; i++) resp[i] = 8'($urandom);
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] data);
        int w = 0;
        while (!cmd_if.cmd_ready && w < 2000) begin tick(); w++; end
        chk("ready_wait", 64'(cmd_if.cmd_ready), 64'(1));
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        tick();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'($urandom);
        cmd_if.cmd_data  = 16'($urandom);
    endtask

    task automatic check_frame(input frame_t f, input logic [2:0] op, input logic [15:0] data);
        int nb = exp_nbytes(op);
        chk("nbits", 64'(f.rises), 64'(nb * 8));
        chk("mosi_bytes", 64'(f.bits), 64'(exp_bits(op, data)));
        chk("cs_low_len", 64'(f.low), 64'(CS_SETUP + nb*16*CLK_DIV + (nb-1)*BYTE_GAP + CS_HOLD));
        chk("setup_len", 64'(f.first_fall - f.start_cyc), 64'(CS_SETUP));
        chk("done_at_cs_rise", 64'(f.done_at_end), 64'(1));
        chk("fbv_at_cs_rise", 64'(f.fbv), 64'(op == 3'd6));
        exp_done++;
        if (op == 3'd6) begin
            exp_fbv++;
            exp_fb = {resp[4], resp[3], resp[2], resp[1]};
            chk("fb_data_at_done", 64'(f.fbd), 64'(exp_fb));
        end
        last_low = f.low;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [15:0] data);
        int     w = 0;
        int     falls0;
        frame_t f;
        issue(op, data);
        if (op == 3'd7) begin
            falls0 = cs_fall_cnt;
`ifdef SPI_MASTER_CMD_QUEUE_EN
            chk("err_early", 64'(cmd_if.cmd_err), 64'(0));
            tick();
`else
            chk("err_ready_low", 64'(cmd_if.cmd_ready), 64'(0));
`endif
            chk("err_pulse", 64'(cmd_if.cmd_err), 64'(1));
            tick();
            chk("err_clear", 64'(cmd_if.cmd_err), 64'(0));
            chk("err_ready_back", 64'(cmd_if.cmd_ready), 64'(1));
            exp_err++;
            repeat (20) tick();
            chk("err_no_cs", 64'(cs_fall_cnt - falls0), 64'(0));
            return;
        end
`ifndef SPI_MASTER_CMD_QUEUE_EN
        chk("acc_cs_low", 64'(cs_n), 64'(0));
        chk("acc_ready_low", 64'(cmd_if.cmd_ready), 64'(0));
`endif
        chk("acc_busy", 64'(cmd_if.busy), 64'(1));
        while (frames.size() == 0 && w < 30000) begin tick(); w++; end
        if (frames.size() == 0) begin
            chk("frame_timeout", 64'(0), 64'(1));
            return;
        end
        f = frames.pop_front();
        check_frame(f, op, data);
        w = 0;
        while (cmd_if.busy && w < 200) begin tick(); w++; end
        chk("hold_tail", 64'(cyc - f.end_cyc), 64'(CS_HOLD));
        chk("ready_after_hold", 64'(cmd_if.cmd_ready), 64'(1));
        chk("fb_data_kept", 64'(cmd_if.fb_data), 64'(exp_fb));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  qop  [5];
        logic [15:0] qdat [5];
        logic [2:0]  op;
        logic [15:0] data;
        frame_t      f;
        int          w;

        rst_n            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_data  = '0;
        for (int i = 0; i < 5; i++) resp[i] = 8'hFF;
        repeat (3) tick();
        chk("rst_sclk", 64'(sclk), 64'(1));
        chk("rst_cs_n", 64'(cs_n), 64'(1));
        chk("rst_mosi", 64'(mosi), 64'(1));
        chk("rst_ready", 64'(cmd_if.cmd_ready), 64'(1));
        chk("rst_busy", 64'(cmd_if.busy), 64'(0));
        chk("rst_done", 64'(cmd_if.done), 64'(0));
        chk("rst_err", 64'(cmd_if.cmd_err), 64'(0));
        chk("rst_fbv", 64'(cmd_if.fb_valid), 64'(0));
        chk("rst_fbd", 64'(cmd_if.fb_data), 64'(0));
        rst_n = 1'b1;
        tick();

        rand_resp();
        run_cmd(3'd0, 16'h0000);
        rand_resp();
        run_cmd(3'd2, 16'h1234);
        chk("ton_cs_low_428", 64'(last_low), 64'(428));
        resp[0] = 8'h5A; resp[1] = 8'h78; resp[2] = 8'h56; resp[3] = 8'h34; resp[4] = 8'h12;
        run_cmd(3'd6, 16'hBEEF);
        chk("fb_12345678", 64'(cmd_if.fb_data), 64'h12345678);
        run_cmd(3'd7, 16'h0000);

        // Abort a WAVEFORM frame in its second byte.
        rand_resp();
        issue(3'd5, 16'($urandom));
        w = 0;
        while (fr.rises < 12 && w < 5000) begin tick(); w++; end
        chk("abort_reached_byte2", 64'(fr.rises >= 12), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 64'(cs_n), 64'(1));
        chk("abort_sclk", 64'(sclk), 64'(1));
        chk("abort_mosi", 64'(mosi), 64'(1));
        chk("abort_busy", 64'(cmd_if.busy), 64'(0));
        chk("abort_ready", 64'(cmd_if.cmd_ready), 64'(1));
        chk("abort_fbd", 64'(cmd_if.fb_data), 64'(0));
        exp_fb = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("abort_no_frame", 64'(frames.size()), 64'(0));
        rand_resp();
        run_cmd(3'd5, 16'hA55A);

        for (int i = 0; i < 12; i++) begin
            op   = 3'($urandom_range(7, 0));
            data = 16'($urandom);
            rand_resp();
            run_cmd(op, data);
        end

`ifdef SPI_MASTER_CMD_QUEUE_EN
        rand_resp();
        for (int i = 0; i < 5; i++) begin
            qop[i]  = 3'($urandom_range(5, 0));
            qdat[i] = 16'($urandom);
        end
        for (int i = 0; i < 5; i++) begin
            chk("q_ready_push", 64'(cmd_if.cmd_ready), 64'(1));
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_op    = qop[i];
            cmd_if.cmd_data  = qdat[i];
            tick();
        end
        cmd_if.cmd_valid = 1'b0;
        chk("q_full_ready_low", 64'(cmd_if.cmd_ready), 64'(0));
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (frames.size() == 0 && w < 30000) begin tick(); w++; end
            if (frames.size() == 0) chk("q_frame_timeout", 64'(0), 64'(1));
            else begin
                f = frames.pop_front();
                check_frame(f, qop[k], qdat[k]);
                if (k > 0) chk("q_cs_high_gap", 64'(f.gap), 64'(CS_HOLD));
            end
        end
        w = 0;
        while (cmd_if.busy && w < 200) begin tick(); w++; end
        chk("q_idle", 64'(cmd_if.busy), 64'(0));
`endif

        repeat (4) tick();
        chk("done_pulses", 64'(done_cnt), 64'(exp_done));
        chk("fbv_pulses", 64'(fbv_cnt), 64'(exp_fbv));
        chk("err_pulses", 64'(err_cnt), 64'(exp_err));
        chk("stray_events", 64'(stray), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
